debounce_edge: RTL and testbench

DEBOUNCE_EDGE -- requirements
Module: debounce_edge

---
 rtl/debounce_edge.sv | 83 ++++++++
 tb/tb_debounce_edge.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// Synchronizes and debounces an asynchronous level, with registered rise/fall pulses.
// A new level is accepted only after it persists DEBOUNCE_CYCLES consecutive cycles at the synchronizer output.
//
// state   | meaning
// STABLE  | synchronized input matches q, counter idle
// PENDING | synchronized input differs from q, counting toward acceptance
module debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            level_q;
  logic            rise_q;
  logic            fall_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign s      = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Any cycle where s agrees with q discards the partial count (bounce rejection).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (s != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= s;
          rise_q  <= s;
          fall_q  <= ~s;
          cnt_q   <= '0;
          state_q <= STABLE;
        end else begin
          cnt_q   <= cnt_q + CW'(1);
          state_q <= PENDING;
        end
      end else begin
        cnt_q   <= '0;
        state_q <= STABLE;
      end
    end
  end

  assign q    = level_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == PENDING);

endmodule

// File: tb/tb_debounce_edge.sv
// Directed self-checking bench for debounce_edge (default parameters plus a DEBOUNCE_CYCLES=1 instance).
module tb_debounce_edge;

  logic clk;
  logic reset;
  logic din;
  logic q, rise, fall, busy;
  logic q1, rise1, fall1, busy1;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .q    (q1),
    .rise (rise1),
    .fall (fall1),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic eq, input logic er,
                           input logic ef, input logic eb);
    check({tag, ".q"},    q,    eq);
    check({tag, ".rise"}, rise, er);
    check({tag, ".fall"}, fall, ef);
    check({tag, ".busy"}, busy, eb);
  endtask

  // Reference model state for the random section
  logic sm0, sm1, qm, rm, fm;
  int   run;
  logic s_old;

  initial begin
    reset = 1'b0;
    din   = 1'b0;

    // Reset held, then idle with din=0
    #3;
    check_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    #7 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // 0->1: busy after E0+2..E0+4, q/rise at E0+5
    din = 1'b1;
    tick(); check_all("r_e0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); check_all("r_e1", 1'b0, 1'b0, 1'b0, 1'b0);
    check("d1_e1.q", q1, 1'b0);
    tick(); check_all("r_e2", 1'b0, 1'b0, 1'b0, 1'b1);
    check("d1_e2.q", q1, 1'b1);
    check("d1_e2.rise", rise1, 1'b1);
    check("d1_e2.busy", busy1, 1'b0);
    tick(); check_all("r_e3", 1'b0, 1'b0, 1'b0, 1'b1);
    check("d1_e3.rise", rise1, 1'b0);
    check("d1_e3.q", q1, 1'b1);
    tick(); check_all("r_e4", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); check_all("r_e5", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_all("r_e6", 1'b1, 1'b0, 1'b0, 1'b0);

    // 1->0: symmetric with fall
    din = 1'b0;
    tick(); check_all("f_e0", 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); check_all("f_e1", 1'b1, 1'b0, 1'b0, 1'b0);
    check("d1_f_e1.fall", fall1, 1'b0);
    tick(); check_all("f_e2", 1'b1, 1'b0, 1'b0, 1'b1);
    check("d1_f_e2.fall", fall1, 1'b1);
    check("d1_f_e2.q", q1, 1'b0);
    tick(); check_all("f_e3", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); check_all("f_e4", 1'b1, 1'b0, 1'b0, 1'b1);
    tick(); check_all("f_e5", 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); check_all("f_e6", 1'b0, 1'b0, 1'b0, 1'b0);

    // Two-cycle glitch is rejected
    din = 1'b1;
    tick(); tick();
    din = 1'b0;
    tick(); check_all("g_e2", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); check_all("g_e3", 1'b0, 1'b0, 1'b0, 1'b1);
    tick(); check_all("g_e4", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all($sformatf("g_tail%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Bounce 1,0,1,0 then steady 1: single rise 5 edges after last 0->1
    din = 1'b1; tick();
    din = 1'b0; tick();
    din = 1'b1; tick();
    din = 1'b0; tick();
    check("b_pre.q", q, 1'b0);
    din = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("b_e%0d.q", i), q, 1'b0);
      check($sformatf("b_e%0d.rise", i), rise, 1'b0);
    end
    tick(); check_all("b_e5", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_all("b_e6", 1'b1, 1'b0, 1'b0, 1'b0);

    // Async reset mid-count, then release with din=1
    din = 1'b0;
    tick(); tick(); tick();
    check("m_pending.busy", busy, 1'b1);
    #1 reset = 1'b0;
    #1;
    check_all("m_in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    din = 1'b1;
    #6 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("m_e%0d.q", i), q, 1'b0);
      check($sformatf("m_e%0d.rise", i), rise, 1'b0);
      check($sformatf("m_e%0d.fall", i), fall, 1'b0);
    end
    tick(); check_all("m_e5", 1'b1, 1'b1, 1'b0, 1'b0);
    tick(); check_all("m_e6", 1'b1, 1'b0, 1'b0, 1'b0);

    // Random toggling against a run-length model
    reset = 1'b0;
    din   = 1'b0;
    #5 reset = 1'b1;
    sm0 = 1'b0; sm1 = 1'b0; qm = 1'b0; rm = 1'b0; fm = 1'b0; run = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) din = ~din;
      tick();
      s_old = sm1;
      sm1   = sm0;
      sm0   = din;
      rm    = 1'b0;
      fm    = 1'b0;
      if (s_old != qm) begin
        run++;
        if (run == 4) begin
          qm  = s_old;
          rm  = s_old;
          fm  = ~s_old;
          run = 0;
        end
      end else begin
        run = 0;
      end
      check_all($sformatf("rnd%0d", i), qm, rm, fm, (run != 0));
      check($sformatf("rnd%0d.overlap", i), rise & fall, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
